// File: rtl/mic_sample_decimator_pkg.sv
// Shared definitions for the microphone decimation path: the audio sample
// width, the default decimation limits and the pick/average mode encoding.
package mic_sample_decimator_pkg;

   localparam int AUDIO_DATA_W       = 16;
   localparam int DEFAULT_MAX_LOG2   = 4;
   localparam int DEFAULT_FIFO_DEPTH = 16;

   typedef enum logic {
      MODE_PICK = 1'b0,
      MODE_AVG  = 1'b1
   } decimMode_t;

   // Limits a requested decimation exponent to the largest one the
   // counter and accumulator were sized for.
   function automatic int clampLog2(input int k, input int maxLog2);
      return (k > maxLog2) ? maxLog2 : k;
   endfunction

endpackage

// File: rtl/mic_sample_decimator_sync_fifo.sv
// Show-ahead synchronous FIFO. The head word is kept in a register so the
// output holds its last value once the FIFO drains, and a write into a full
// FIFO is accepted when a pop frees a slot on the same edge.
module sync_fifo #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 16,
   parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               wr_en,
   input  logic [WIDTH-1:0]   wr_data,
   input  logic               rd_en,
   output logic [WIDTH-1:0]   rd_data,
   output logic [LEVEL_W-1:0] level,
   output logic               full,
   output logic               empty
);

   localparam int                 PTR_W      = $clog2(DEPTH);
   localparam logic [PTR_W-1:0]   PTR_ONE    = 1;
   localparam logic [LEVEL_W-1:0] LEVEL_ONE  = 1;
   localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wrPtr;
   logic [PTR_W-1:0]   r_rdPtr;
   logic [LEVEL_W-1:0] r_level;
   logic [WIDTH-1:0]   r_head;

   logic w_pop;
   logic w_push;
   logic w_full;
   logic w_empty;

   // A pop needs data present; a push needs room, or a pop on the same edge
   always_comb begin
      w_empty = (r_level == '0);
      w_full  = (r_level == LEVEL_FULL);
      w_pop   = rd_en & ~w_empty;
      w_push  = wr_en & (~w_full | w_pop);
   end

   // Storage array; contents need no reset because the level guards reads
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_ONE;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LEVEL_ONE;
            2'b01:   r_level <= r_level - LEVEL_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

   // Head register: advance to the next stored word on a pop, load the
   // incoming word when it becomes the only entry, otherwise hold
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_head <= '0;
      end else if (w_pop && (r_level > LEVEL_ONE)) begin
         r_head <= r_mem[r_rdPtr + PTR_ONE];
      end else if (w_push && ((r_level == '0) || (w_pop && (r_level == LEVEL_ONE)))) begin
         r_head <= wr_data;
      end
   end

   assign rd_data = r_head;
   assign level   = r_level;
   assign full    = w_full;
   assign empty   = w_empty;

endmodule

// File: rtl/mic_sample_decimator.sv
// Reduces the PCM stream from the PDM filter by a runtime power-of-two
// factor, either keeping the last sample of each group or averaging the
// group, and queues results in a FIFO for stallable consumers.
module mic_sample_decimator
   import mic_sample_decimator_pkg::*;
#(
   parameter int DATA_W     = AUDIO_DATA_W,
   parameter int MAX_LOG2   = DEFAULT_MAX_LOG2,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            enable_i,
   input  logic                            mode_i,
   input  logic [2:0]                      decim_log2_i,
   input  logic                            clr_ovf_i,
   input  logic                            fs_i,
   input  logic [DATA_W-1:0]               data_i,
   output logic                            out_valid_o,
   output logic [DATA_W-1:0]               out_data_o,
   input  logic                            out_ready_i,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o,
   output logic                            overflow_o
);

   localparam int                  KW      = $clog2(MAX_LOG2 + 1);
   localparam int                  ACC_W   = DATA_W + MAX_LOG2;
   localparam int                  LEVEL_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [MAX_LOG2-1:0] CNT_ONE = 1;
   localparam logic [MAX_LOG2:0]   SIZE_ONE = 1;

   logic                      r_fsQ;
   logic                      r_fsQq;
   logic signed [DATA_W-1:0]  r_dataQ;
   decimMode_t                r_mode;
   logic [KW-1:0]             r_k;
   logic [MAX_LOG2-1:0]       r_cnt;
   logic signed [ACC_W-1:0]   r_acc;
   logic                      r_overflow;

   logic                      w_rise;
   logic                      w_groupStart;
   logic [KW-1:0]             w_kReq;
   logic [KW-1:0]             w_kEff;
   decimMode_t                w_modeEff;
   logic [MAX_LOG2:0]         w_groupSize;
   logic [MAX_LOG2-1:0]       w_lastCnt;
   logic                      w_final;
   logic signed [ACC_W-1:0]   w_sample;
   logic signed [ACC_W-1:0]   w_sum;
   logic signed [ACC_W-1:0]   w_shifted;
   logic [DATA_W-1:0]         w_result;
   logic                      w_wrEn;
   logic                      w_full;
   logic                      w_empty;
   logic                      w_drop;

   // Strobe edge detection and sample alignment: data is delayed by one
   // cycle so it lines up with the detected rising edge
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fsQ   <= 1'b0;
         r_fsQq  <= 1'b0;
         r_dataQ <= '0;
      end else begin
         r_fsQ   <= fs_i;
         r_fsQq  <= r_fsQ;
         r_dataQ <= data_i;
      end
   end

   // Group arithmetic. The first sample of a group uses the live config
   // inputs (that is the moment they get latched); later samples use the
   // latched copy so mid-group changes wait for the next group.
   always_comb begin
      w_rise       = r_fsQ & ~r_fsQq;
      w_groupStart = (r_cnt == '0);
      w_kReq       = KW'(clampLog2(int'(decim_log2_i), MAX_LOG2));
      w_kEff       = w_groupStart ? w_kReq : r_k;
      w_modeEff    = w_groupStart ? decimMode_t'(mode_i) : r_mode;
      w_groupSize  = SIZE_ONE << w_kEff;
      w_lastCnt    = w_groupSize[MAX_LOG2-1:0] - CNT_ONE;
      w_final      = (r_cnt == w_lastCnt);
      w_sample     = {{MAX_LOG2{r_dataQ[DATA_W-1]}}, r_dataQ};
      w_sum        = w_groupStart ? w_sample : (r_acc + w_sample);
      w_shifted    = w_sum >>> w_kEff;
      w_result     = (w_modeEff == MODE_AVG) ? w_shifted[DATA_W-1:0] : r_dataQ;
      w_wrEn       = enable_i & w_rise & w_final;
      w_drop       = w_wrEn & w_full & ~out_ready_i;
   end

   // Group counter, accumulator and config latch; disabling capture
   // discards any partial group
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt  <= '0;
         r_acc  <= '0;
         r_k    <= '0;
         r_mode <= MODE_PICK;
      end else if (!enable_i) begin
         r_cnt <= '0;
         r_acc <= '0;
      end else if (w_rise) begin
         if (w_groupStart) begin
            r_k    <= w_kReq;
            r_mode <= decimMode_t'(mode_i);
         end
         r_cnt <= w_final ? '0 : (r_cnt + CNT_ONE);
         r_acc <= w_sum;
      end
   end

   // Sticky overflow flag; a new drop outranks a clear on the same edge
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_ovf_i) begin
         r_overflow <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH   (DATA_W),
      .DEPTH   (FIFO_DEPTH),
      .LEVEL_W (LEVEL_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .wr_en   (w_wrEn),
      .wr_data (w_result),
      .rd_en   (out_ready_i),
      .rd_data (out_data_o),
      .level   (level_o),
      .full    (w_full),
      .empty   (w_empty)
   );

   assign out_valid_o = ~w_empty;
   assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_mic_sample_decimator.sv
// Directed bench for mic_sample_decimator: pick/average decimation,
// config latching, FIFO full/overflow handling, enable and reset behaviour.
module tb_mic_sample_decimator;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        mode;
   logic [2:0]  decimLog2;
   logic        clrOvf;
   logic        fs;
   logic [15:0] data;
   logic        outValid;
   logic [15:0] outData;
   logic        outReady;
   logic [4:0]  level;
   logic        overflow;

   int assertCount = 0;
   int failCount   = 0;

   mic_sample_decimator dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .enable_i     (enable),
      .mode_i       (mode),
      .decim_log2_i (decimLog2),
      .clr_ovf_i    (clrOvf),
      .fs_i         (fs),
      .data_i       (data),
      .out_valid_o  (outValid),
      .out_data_o   (outData),
      .out_ready_i  (outReady),
      .level_o      (level),
      .overflow_o   (overflow)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison point: counts it and reports a mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkData(input string tag, input int expected);
      logic [15:0] exp16;
      exp16 = 16'(expected);
      checkOutput(tag, {16'h0, outData}, {16'h0, exp16});
   endtask

   task automatic checkLevel(input string tag, input int expected);
      checkOutput(tag, {27'h0, level}, 32'(expected));
   endtask

   // One strobe pulse, starting and ending on a falling clock edge
   task automatic applyStimulus(input int value, input int highCycles, input int lowCycles);
      @(negedge clk);
      fs   = 1'b1;
      data = 16'(value);
      repeat (highCycles) @(negedge clk);
      fs = 1'b0;
      repeat (lowCycles - 1) @(negedge clk);
   endtask

   // Checks the head word, then pops it with a single-cycle ready
   task automatic popWord(input string tag, input int expected);
      checkData(tag, expected);
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      enable    = 1'b0;
      mode      = 1'b0;
      decimLog2 = 3'd0;
      clrOvf    = 1'b0;
      fs        = 1'b0;
      data      = 16'h0;
      outReady  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_valid", {31'h0, outValid}, 32'h0);
      checkLevel("reset_level", 0);
      checkOutput("reset_ovf", {31'h0, overflow}, 32'h0);
      checkData("reset_data", 0);
      rst    = 1'b0;
      enable = 1'b1;

      // Pass-through pick mode with 3-cycle strobes and latency check
      $display("[TB] pass-through pick mode");
      @(negedge clk);
      fs   = 1'b1;
      data = 16'h0001;
      @(posedge clk);
      #1 checkOutput("lat_edge1_valid", {31'h0, outValid}, 32'h0);
      @(posedge clk);
      #1 checkOutput("lat_edge2_valid", {31'h0, outValid}, 32'h1);
      @(negedge clk);
      @(negedge clk);
      fs = 1'b0;
      repeat (9) @(negedge clk);
      applyStimulus(2, 3, 10);
      applyStimulus(3, 3, 10);
      checkLevel("k0_level", 3);
      popWord("k0_word1", 1);
      popWord("k0_word2", 2);
      popWord("k0_word3", 3);

      // Average of four, positive then negative floor case
      $display("[TB] average mode k=2");
      mode      = 1'b1;
      decimLog2 = 3'd2;
      applyStimulus(4, 3, 4);
      applyStimulus(8, 3, 4);
      applyStimulus(-4, 3, 4);
      checkLevel("avg_partial_level", 0);
      applyStimulus(12, 3, 4);
      popWord("avg_pos", 5);
      applyStimulus(-1, 3, 4);
      applyStimulus(-1, 3, 4);
      applyStimulus(-1, 3, 4);
      applyStimulus(-2, 3, 4);
      popWord("avg_neg_floor", -2);

      // Pick every 2nd; exponent changed mid-group only applies to the
      // group that begins after that group completes
      $display("[TB] pick mode k=1 with mid-group change");
      mode      = 1'b0;
      decimLog2 = 3'd1;
      applyStimulus(10, 3, 4);
      applyStimulus(20, 3, 4);
      applyStimulus(30, 3, 4);
      decimLog2 = 3'd3;
      applyStimulus(40, 3, 4);
      checkLevel("k1_level", 2);
      for (int i = 0; i < 7; i++) applyStimulus(50 + i, 3, 4);
      checkLevel("k3_partial_level", 2);
      applyStimulus(57, 3, 4);
      checkLevel("k3_level", 3);
      popWord("k1_word1", 20);
      popWord("k1_word2", 40);
      popWord("k3_word", 57);

      // Fill past capacity with the consumer stalled
      $display("[TB] FIFO full and overflow");
      decimLog2 = 3'd0;
      for (int i = 1; i <= 18; i++) applyStimulus(i, 3, 4);
      checkLevel("full_level", 16);
      checkOutput("full_ovf", {31'h0, overflow}, 32'h1);
      checkData("full_head", 1);
      clrOvf = 1'b1;
      @(negedge clk);
      clrOvf = 1'b0;
      checkOutput("ovf_cleared", {31'h0, overflow}, 32'h0);
      // Write lands on the second rising edge; pop on that same edge
      @(negedge clk);
      fs   = 1'b1;
      data = 16'd19;
      @(negedge clk);
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      checkLevel("full_pop_level", 16);
      checkOutput("full_pop_ovf", {31'h0, overflow}, 32'h0);
      @(negedge clk);
      fs = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 2; i <= 16; i++) popWord("drain", i);
      popWord("drain_last", 19);
      checkOutput("drain_valid", {31'h0, outValid}, 32'h0);
      checkData("empty_hold", 19);
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      checkLevel("empty_pop_level", 0);

      // Disabling mid-group discards the partial sum
      $display("[TB] enable drop mid-group");
      mode      = 1'b1;
      decimLog2 = 3'd2;
      applyStimulus(100, 3, 4);
      applyStimulus(100, 3, 4);
      enable = 1'b0;
      repeat (5) @(negedge clk);
      enable = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1, 3, 4);
      checkLevel("reenable_partial", 0);
      applyStimulus(1, 3, 4);
      checkLevel("reenable_level", 1);
      popWord("reenable_avg", 1);

      // Reset with queued words and a partial group
      $display("[TB] reset mid-operation");
      mode      = 1'b0;
      decimLog2 = 3'd0;
      for (int i = 0; i < 5; i++) applyStimulus(70 + i, 3, 4);
      decimLog2 = 3'd2;
      applyStimulus(80, 3, 4);
      applyStimulus(81, 3, 4);
      checkLevel("pre_reset_level", 5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_valid", {31'h0, outValid}, 32'h0);
      checkLevel("rst_level", 0);
      checkOutput("rst_ovf", {31'h0, overflow}, 32'h0);
      checkData("rst_data", 0);
      applyStimulus(1, 3, 4);
      applyStimulus(2, 3, 4);
      checkLevel("fresh_partial", 0);
      applyStimulus(3, 3, 4);
      applyStimulus(4, 3, 4);
      checkLevel("fresh_level", 1);
      popWord("fresh_pick", 4);

      // Exponent above the limit behaves as 16-sample groups
      $display("[TB] clamped exponent");
      mode      = 1'b1;
      decimLog2 = 3'd7;
      for (int i = 0; i < 15; i++) applyStimulus(3, 3, 4);
      checkLevel("clamp_partial", 0);
      applyStimulus(3, 3, 4);
      checkLevel("clamp_level", 1);
      popWord("clamp_avg", 3);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
